// File: rtl/mul_div_if.sv
// Request/result bundle between the EX-stage control and the
// sequential multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, Signal, dataA, dataB,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Sequential unsigned MULTU/DIVU unit writing the HI/LO pair.
// One radix-2 iteration per clock; HI/LO only move on DONE entry.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mul_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t next;

  logic [CW-1:0]    count;
  logic             op_div;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dz_q;

  logic is_mul;
  logic is_div;
  logic accept;
  logic iter;
  logic finish;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign is_mul = bus.Signal == F_MULTU;
  assign is_div = bus.Signal == F_DIVU;
  assign accept = (state == IDLE) && bus.start
                  && (is_mul || is_div);
  assign iter   = (state == RUN) && (count != LAST);
  assign finish = (state == RUN) && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = RUN;
      RUN:     if (finish) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Shift-add: carry of the upper-half add re-enters at the top.
  always_comb begin
    mul_sum = {1'b0, acc_hi};
    if (acc_lo[0]) mul_sum = {1'b0, acc_hi} + {1'b0, a_q};
    mul_hi = mul_sum[WIDTH:1];
    mul_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // Restoring step; a zero divisor never borrows, giving all-ones.
  always_comb begin
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_q};
    borrow = trial[WIDTH+1];
    div_hi = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    div_lo = {acc_lo[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      op_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          count  <= '0;
          op_div <= is_div;
          a_q    <= bus.dataA;
          b_q    <= bus.dataB;
          acc_hi <= '0;
          acc_lo <= is_div ? bus.dataA : bus.dataB;
          dz_q   <= 1'b0;
        end
        iter: begin
          count  <= count + 1'b1;
          acc_hi <= op_div ? div_hi : mul_hi;
          acc_lo <= op_div ? div_lo : mul_lo;
        end
        finish: begin
          hi_q <= acc_hi;
          lo_q <= acc_lo;
          dz_q <= op_div && (b_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = state != IDLE;
  assign bus.done    = state == DONE;
  assign bus.divZero = dz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; a monitor pops expected
// HI/LO/divZero from a scoreboard queue on every done pulse.
module tb_mul_div_unit;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  mul_div_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.done === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done=1 expected 0");
      end else begin
        e = sb.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo
            || bus.divZero !== e.dz) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   bus.hi, bus.lo, bus.divZero, e.hi, e.lo, e.dz);
        end
      end
    end
  end

  // Call on a negedge; returns after the accepting posedge.
  task automatic issue(input logic [5:0] f,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.Signal = f;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.Signal = 6'd0;
    bus.dataA  = '0;
    bus.dataB  = '0;
  endtask

  // Counts negedges after the accepting edge until done.
  task automatic wait_done(output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) bsy++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within %0d cycles", cyc);
    end
  endtask

  task automatic run(input string name,
                     input logic [5:0] f,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] ehi,
                     input logic [W-1:0] elo,
                     input logic edz);
    int cyc;
    int bsy;
    sb.push_back('{ehi, elo, edz});
    issue(f, a, b);
    wait_done(cyc, bsy);
    chk({name, "_latency"}, W'(cyc), W'(34));
    @(negedge clk);
    chk({name, "_done_pulse"}, W'(bus.done), W'(0));
  endtask

  initial begin
    int cyc;
    int bsy;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.Signal = 6'd0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_dz", W'(bus.divZero), W'(0));
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: full-width multiply
    run("multu_max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // 2: divide with busy/done timing
    sb.push_back('{32'd2, 32'd14, 1'b0});
    issue(6'd27, 32'd100, 32'd7);
    wait_done(cyc, bsy);
    chk("divu_latency", W'(cyc), W'(34));
    chk("divu_busy_cycles", W'(bsy), W'(33));
    chk("divu_busy_in_done", W'(bus.busy), W'(1));
    @(negedge clk);
    chk("divu_done_width", W'(bus.done), W'(0));
    chk("divu_busy_after", W'(bus.busy), W'(0));

    run("divu_small", 6'd27, 32'd7, 32'd100,
        32'd7, 32'd0, 1'b0);

    // 3: divide by zero, then cleared by next start
    run("divu_zero", 6'd27, 32'h1234_5678, 32'd0,
        32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    chk("dz_held", W'(bus.divZero), W'(1));
    sb.push_back('{32'd0, 32'd15, 1'b0});
    issue(6'd25, 32'd3, 32'd5);
    chk("dz_cleared", W'(bus.divZero), W'(0));
    wait_done(cyc, bsy);
    @(negedge clk);

    // 4: start while busy is ignored; old result visible during RUN
    sb.push_back('{32'd0, 32'd42, 1'b0});
    issue(6'd25, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    chk("run_hold_hi", bus.hi, 32'd0);
    chk("run_hold_lo", bus.lo, 32'd15);
    bus.start  = 1'b1;
    bus.Signal = 6'd27;
    bus.dataA  = 32'd9;
    bus.dataB  = 32'd2;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.Signal = 6'd0;
    wait_done(cyc, bsy);
    chk("ignored_start_latency", W'(cyc + 11), W'(34));
    @(negedge clk);
    chk("no_queue", W'(bus.busy), W'(0));

    // 5: reset mid-RUN aborts with no done
    issue(6'd25, 32'h0001_0000, 32'h0001_0000);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_done", W'(bus.done), W'(0));
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", W'(bus.busy), W'(0));
    run("multu_pow", 6'd25, 32'h0001_0000, 32'h0001_0000,
        32'd1, 32'd0, 1'b0);

    run("multu_mix", 6'd25, 32'h1234_5678, 32'h10,
        32'h1, 32'h2345_6780, 1'b0);

    // 6: back-to-back request with a non-op funct
    sb.push_back('{32'hF, 32'h0FFF_FFFF, 1'b0});
    issue(6'd27, 32'hFFFF_FFFF, 32'h10);
    wait_done(cyc, bsy);
    issue(6'd32, 32'd1, 32'd1);
    repeat (40) @(negedge clk);
    chk("noop_busy", W'(bus.busy), W'(0));
    chk("noop_hi", bus.hi, 32'hF);
    chk("noop_lo", bus.lo, 32'h0FFF_FFFF);
    chk("sb_empty", W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
